wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 111 +++++++++++
 tb/tb_wb_regfile.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- 32 x 32-bit integer register file with writeback select.
//
// Selects the writeback value from the W-stage sources, commits it into the
// register array on the rising clock edge and counts committed writes.
// x0 reads as zero and never accepts a write. Reads are asynchronous.
//
// Optional feature (macro WB_REGFILE_BYPASS_EN):
//   defined   : a read whose index matches an in-progress commit returns the
//               value being written (write-through bypass).
//   undefined : such a read returns the value stored before the write; the
//               forwarding unit resolves that hazard using wb_data.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   rd_wr_enW  in   1   writeback enable from W stage
//   wb_selW    in   2   writeback source: 0 alu, 1 lsu, 2 pc4, 3 none
//   alu_dataW  in  32   ALU result candidate
//   lsu_dataW  in  32   load data candidate
//   pc4W       in  32   PC+4 candidate (link value)
//   rd_addrW   in   5   destination register index
//   rs1_addr   in   5   read port 1 index
//   rs2_addr   in   5   read port 2 index
//   rs1_data   out 32   read port 1 data (combinational)
//   rs2_data   out 32   read port 2 data (combinational)
//   wb_data    out 32   selected writeback value (combinational)
//   wb_valid   out  1   a commit happens this cycle (combinational)
//   wb_count   out 32   registered count of committed writes
// ---------------------------------------------------------------------------
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_wr_enW,
  input  logic [1:0]  wb_selW,
  input  logic [31:0] alu_dataW,
  input  logic [31:0] lsu_dataW,
  input  logic [31:0] pc4W,
  input  logic [4:0]  rd_addrW,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic [31:0] wb_count
);

  // Registers need an asynchronous clear, so the array maps to flops rather
  // than block RAM. Entry 0 is never written and is masked on read anyway.
  logic [31:0] regs_reg [32];
  logic [31:0] wb_count_reg;
  logic        commit;

  always_comb begin
    wb_data = 32'h0;
    case (wb_selW)
      2'd0:    wb_data = alu_dataW;
      2'd1:    wb_data = lsu_dataW;
      2'd2:    wb_data = pc4W;
      default: wb_data = 32'h0;
    endcase
  end

  assign commit   = rd_wr_enW && (rd_addrW != 5'd0) && (wb_selW != 2'd3);
  assign wb_valid = commit;
  assign wb_count = wb_count_reg;

  // One register slice per architectural register.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= 32'h0;
        end else if (commit && (rd_addrW == 5'(gi))) begin
          regs_reg[gi] <= wb_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_reg <= 32'h0;
    end else if (commit) begin
      wb_count_reg <= wb_count_reg + 32'd1;  // wraps naturally at 2^32
    end
  end

  // Read path shared by both ports. x0 is forced to zero ahead of any bypass.
  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] val;
    val = 32'h0;
    if (addr != 5'd0) begin
      val = regs_reg[addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (commit && (addr == rd_addrW)) begin
        val = wb_data;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile -- self-checking bench for wb_regfile.
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model (plain array + counter) held in the bench.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        rd_wr_enW;
  logic [1:0]  wb_selW;
  logic [31:0] alu_dataW;
  logic [31:0] lsu_dataW;
  logic [31:0] pc4W;
  logic [4:0]  rd_addrW;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] wb_count;

  wb_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_wr_enW (rd_wr_enW),
    .wb_selW   (wb_selW),
    .alu_dataW (alu_dataW),
    .lsu_dataW (lsu_dataW),
    .pc4W      (pc4W),
    .rd_addrW  (rd_addrW),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_data   (wb_data),
    .wb_valid  (wb_valid),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  int          tests_run;
  int          tests_failed;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_wbdata();
    case (wb_selW)
      2'd0:    return alu_dataW;
      2'd1:    return lsu_dataW;
      2'd2:    return pc4W;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_commit();
    return rd_wr_enW && rd_addrW != 0 && wb_selW != 2'd3;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYPASS && m_commit() && a == rd_addrW) return m_wbdata();
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_count = 32'h0;
  endtask

  task automatic drive(input logic en, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] lsu, input logic [31:0] pc4,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    rd_wr_enW = en;  wb_selW = sel;  rd_addrW = rd;
    alu_dataW = alu; lsu_dataW = lsu; pc4W = pc4;
    rs1_addr = ra1;  rs2_addr = ra2;
  endtask

  // Compare all combinational outputs against the model for current inputs.
  task automatic check_comb(input string tag);
    check({tag, ".wb_data"},  wb_data, m_wbdata());
    check({tag, ".wb_valid"}, {31'h0, wb_valid}, {31'h0, m_commit()});
    check({tag, ".rs1"},      rs1_data, m_read(rs1_addr));
    check({tag, ".rs2"},      rs2_data, m_read(rs2_addr));
  endtask

  // Advance one clock with reset high, apply the commit to the model and
  // check the counter afterwards.
  task automatic tick(input string tag);
    bit          c;
    logic [31:0] d;
    c = m_commit();
    d = m_wbdata();
    @(posedge clk);
    if (c) begin
      m_regs[rd_addrW] = d;
      m_count = m_count + 32'd1;
    end
    @(negedge clk);
    #1;
    check({tag, ".count"}, wb_count, m_count);
  endtask

  // One full transaction: drive, check combinational view, clock, check count.
  task automatic step(input string tag, input logic en, input logic [1:0] sel, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] lsu, input logic [31:0] pc4,
                      input logic [4:0] ra1, input logic [4:0] ra2);
    drive(en, sel, rd, alu, lsu, pc4, ra1, ra2);
    #1;
    check_comb(tag);
    tick(tag);
    $display("[TB] %s en=%0b sel=%0d rd=%0d rs1=%0d:%08h rs2=%0d:%08h count=%0d",
             tag, en, sel, rd, ra1, rs1_data, ra2, rs2_data, wb_count);
  endtask

  logic [31:0] old9;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state: x5, x31 and counter all zero.
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    #1;
    check("rst.rs1_x5",  rs1_data, 32'h0);
    check("rst.rs2_x31", rs2_data, 32'h0);
    check("rst.count",   wb_count, 32'h0);
    $display("[TB] reset read x5=%08h x31=%08h count=%0d", rs1_data, rs2_data, wb_count);

    // Basic ALU commit, visible next cycle.
    step("alu_wr", 1'b1, 2'd0, 5'd3, 32'h1234_5678, 32'h0, 32'h0, 5'd0, 5'd0);
    step("alu_rd", 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
    check("alu_rd.x3_lit", rs1_data, 32'h1234_5678);
    check("alu_rd.cnt_lit", wb_count, 32'd1);

    // Writes to x0 are dropped.
    drive(1'b1, 2'd2, 5'd0, 32'h0, 32'h0, 32'h44, 5'd0, 5'd3);
    #1;
    check("x0_wr.valid", {31'h0, wb_valid}, 32'h0);
    check("x0_wr.wb_data", wb_data, 32'h44);
    tick("x0_wr");
    check("x0_rd.x0_lit", rs1_data, 32'h0);
    check("x0_rd.cnt_lit", wb_count, 32'd1);
    $display("[TB] x0 write dropped, x0=%08h count=%0d", rs1_data, wb_count);

    // sel=3 never commits.
    step("x7_pre", 1'b1, 2'd0, 5'd7, 32'h0000_0777, 32'h0, 32'h0, 5'd7, 5'd0);
    step("x7_sel3", 1'b1, 2'd3, 5'd7, 32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003, 5'd7, 5'd7);
    check("x7_sel3.x7_lit", rs1_data, 32'h0000_0777);
    check("x7_sel3.cnt_lit", wb_count, 32'd2);

    // Same-cycle read of the register being written.
    step("x9_pre", 1'b1, 2'd0, 5'd9, 32'h0909_0909, 32'h0, 32'h0, 5'd0, 5'd0);
    old9 = 32'h0909_0909;
    drive(1'b1, 2'd1, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd9);
    #1;
    check_comb("x9_same");
    check("x9_same.rs1_lit", rs1_data, BYPASS ? 32'hDEAD_BEEF : old9);
    check("x9_same.rs2_lit", rs2_data, BYPASS ? 32'hDEAD_BEEF : old9);
    tick("x9_same");
    check("x9_after.rs1_lit", rs1_data, 32'hDEAD_BEEF);
    $display("[TB] x9 same-cycle bypass=%0b rs1=%08h", BYPASS, rs1_data);

    // Counter wrap via backdoor preload.
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    force dut.wb_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_reg;
    m_count = 32'hFFFF_FFFF;
    #1;
    check("wrap.preload", wb_count, 32'hFFFF_FFFF);
    step("wrap", 1'b1, 2'd2, 5'd12, 32'h0, 32'h0, 32'h0000_0100, 5'd12, 5'd0);
    check("wrap.cnt_lit", wb_count, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      logic [4:0] a1;
      logic [4:0] a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      step("rand", 1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), rd,
           $urandom, $urandom, $urandom, a1, a2);
    end

    // Reset mid-stream after loading x1..x4.
    for (int i = 1; i <= 4; i++) begin
      step("pre_rst", 1'b1, 2'd0, 5'(i), 32'hA000_0000 + 32'(i), 32'h0, 32'h0, 5'(i), 5'd0);
    end
    drive(1'b1, 2'd0, 5'd5, 32'h5555_5555, 32'h0, 32'h0, 5'd1, 5'd2);
    rst_n = 1'b0;
    m_reset();
    for (int i = 1; i <= 4; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      check($sformatf("in_rst.x%0d_rs1", i), rs1_data, 32'h0);
      check($sformatf("in_rst.x%0d_rs2", i), rs2_data, 32'h0);
    end
    check("in_rst.count", wb_count, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1);
    #1;
    check("post_rst.x5", rs1_data, 32'h0);
    check("post_rst.x1", rs2_data, 32'h0);
    check("post_rst.count", wb_count, 32'h0);
    $display("[TB] mid-stream reset x5=%08h x1=%08h count=%0d", rs1_data, rs2_data, wb_count);
    step("post_rst_wr", 1'b1, 2'd0, 5'd6, 32'h0000_0606, 32'h0, 32'h0, 5'd6, 5'd0);
    step("post_rst_rd", 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd6, 5'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
